piso_shift_register: RTL and testbench

//  Parallel-in/serial-out serializer for the serial link front end.

---
 rtl/piso_shift_register.sv | 55 +++++
 tb/tb_piso_shift_register.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/piso_shift_register.sv
// Parallel-in/serial-out serializer: a free-running bit counter reloads the
// shift register every WIDTH clocks and the word is shifted out one bit per clock.
module piso_shift_register #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] parallel_in,
  output logic             serial_out,
  output logic             frame_sync
);

  localparam int unsigned     CntW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(WIDTH - 1);

  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             loaded_q, loaded_d;
  logic             load;

  // cnt counts down the bits still to send; zero marks the last bit of a frame
  // (or the idle state after reset), so the next edge captures a new word.
  assign load = (cnt_q == '0);

  always_comb begin
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
    loaded_d = loaded_q;
    if (load) begin
      shreg_d  = parallel_in;
      cnt_d    = CntMax;
      loaded_d = 1'b1;
    end else begin
      cnt_d   = cnt_q - CntW'(1);
      shreg_d = LSB_FIRST ? (shreg_q >> 1) : (shreg_q << 1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg_q  <= '0;
      cnt_q    <= '0;
      loaded_q <= 1'b0;
    end else begin
      shreg_q  <= shreg_d;
      cnt_q    <= cnt_d;
      loaded_q <= loaded_d;
    end
  end

  assign serial_out = LSB_FIRST ? shreg_q[0] : shreg_q[WIDTH-1];
  assign frame_sync = loaded_q && (cnt_q == CntMax);

endmodule

// File: tb/tb_piso_shift_register.sv
// Bench for piso_shift_register: LSB-first and MSB-first instances share stimulus and
// are compared every cycle against a queue-of-bits model, plus literal frame checks.
module tb_piso_shift_register;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] parallel_in = 8'hDA;
  logic         so_l, fs_l, so_m, fs_m;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  piso_shift_register #(.WIDTH(W), .LSB_FIRST(1'b1)) dut_lsb (
    .clk(clk), .rst(rst), .parallel_in(parallel_in), .serial_out(so_l), .frame_sync(fs_l)
  );
  piso_shift_register #(.WIDTH(W), .LSB_FIRST(1'b0)) dut_msb (
    .clk(clk), .rst(rst), .parallel_in(parallel_in), .serial_out(so_m), .frame_sync(fs_m)
  );

  always #5 clk = ~clk;

  // Model: each load edge queues the W bits of the captured word in send order;
  // every other edge consumes one bit. The queue head is what must be on the wire.
  bit q_l[$];
  bit q_m[$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q_l.delete();
      q_m.delete();
    end else if (q_l.size() <= 1) begin
      q_l.delete();
      q_m.delete();
      for (int i = 0; i < W; i++) begin
        q_l.push_back(parallel_in[i]);
        q_m.push_back(parallel_in[W-1-i]);
      end
    end else begin
      void'(q_l.pop_front());
      void'(q_m.pop_front());
    end
  end

  function automatic bit exp_so_l();
    return (q_l.size() > 0) ? q_l[0] : 1'b0;
  endfunction
  function automatic bit exp_so_m();
    return (q_m.size() > 0) ? q_m[0] : 1'b0;
  endfunction
  function automatic bit exp_fs();
    return q_l.size() == W;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("serial_out_lsb", 32'(so_l), 32'(exp_so_l()));
      chk("serial_out_msb", 32'(so_m), 32'(exp_so_m()));
      chk("frame_sync_lsb", 32'(fs_l), 32'(exp_fs()));
      chk("frame_sync_msb", 32'(fs_m), 32'(exp_fs()));
    end
  end

  // Sample one full frame (8 cycles) at negedges; bit k of each vector is cycle k.
  task automatic collect(output logic [W-1:0] l, output logic [W-1:0] m,
                         output logic [W-1:0] fs);
    for (int k = 0; k < W; k++) begin
      @(negedge clk);
      l[k]  = so_l;
      m[k]  = so_m;
      fs[k] = fs_l;
    end
  endtask

  // Return at a negedge just before a load edge, judged by the model alone.
  task automatic wait_load();
    for (int n = 0; n < 3 * W; n++) begin
      @(negedge clk);
      if (q_l.size() == 1) return;
    end
    chk("wait_load_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    logic [W-1:0] l, m, fs;

    // 1: reset with 8'hDA held, then one literal frame.
    cmp_en = 1'b1;
    #1;
    chk("reset_serial_out", 32'({so_l, so_m}), 32'd0);
    chk("reset_frame_sync", 32'({fs_l, fs_m}), 32'd0);
    #11 rst = 1'b0;           // released at t=12, first load at t=15
    collect(l, m, fs);
    chk("frame_DA_lsb", 32'(l), 32'h0000_00DA);   // 0,1,0,1,1,0,1,1
    chk("frame_DA_msb", 32'(m), 32'h0000_005B);   // 1,1,0,1,1,0,1,0
    chk("frame_DA_sync", 32'(fs), 32'h0000_0001);
    collect(l, m, fs);
    chk("frame_DA_repeat", 32'(l), 32'h0000_00DA);
    chk("frame_DA_resync", 32'(fs), 32'h0000_0001);

    // 3: mid-frame change of parallel_in does not disturb the frame in flight.
    wait_load();
    parallel_in = 8'hFF;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    parallel_in = 8'h00;
    for (int k = 3; k < W; k++) @(negedge clk);
    collect(l, m, fs);
    chk("frame_after_FF", 32'(l), 32'h0000_0000);

    // 4: async reset in cycle 4 of an 8'hA5 frame.
    wait_load();
    parallel_in = 8'hA5;
    for (int k = 0; k < 5; k++) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_serial_out", 32'({so_l, so_m}), 32'd0);
    chk("async_rst_frame_sync", 32'({fs_l, fs_m}), 32'd0);
    // 5: hold reset across several edges.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("held_rst_outputs", 32'({so_l, so_m, fs_l, fs_m}), 32'd0);
    end
    #2 rst = 1'b0;
    collect(l, m, fs);
    chk("frame_after_rst_lsb", 32'(l), 32'h0000_00A5);
    chk("frame_after_rst_msb", 32'(m), 32'h0000_00A5 >> 0 & 32'h0 | 32'h0000_00A5);
    chk("frame_after_rst_sync", 32'(fs), 32'h0000_0001);

    // 6: a single-bit source zero-extended onto the bus.
    wait_load();
    parallel_in = '0;
    parallel_in[0] = 1'b1;
    collect(l, m, fs);
    chk("one_bit_lsb", 32'(l), 32'h0000_0001);
    chk("one_bit_msb", 32'(m), 32'h0000_0080);    // MSB-first: 1 arrives last

    // Random words changing at random times, with occasional async resets.
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      if ($urandom_range(0, 2) == 0) parallel_in = W'($urandom);
      if ($urandom_range(0, 59) == 0) begin
        #($urandom_range(1, 4)) rst = 1'b1;
        #1;
        chk("rand_async_rst", 32'({so_l, so_m, fs_l, fs_m}), 32'd0);
        for (int k = $urandom_range(0, 2); k > 0; k--) @(negedge clk);
        #2 rst = 1'b0;
      end
    end

    @(negedge clk);
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
